// File: rtl/led_wrap_pkg.sv
// Shared types and constants for the wrap-around LED pattern monitor.
package led_wrap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LED_OFF = 4'b0000;
  localparam logic [3:0] LED_P0  = 4'b0001;
  localparam logic [3:0] LED_P1  = 4'b0010;
  localparam logic [3:0] LED_P2  = 4'b0100;
  localparam logic [3:0] LED_P3  = 4'b1000;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Position delta modulo 4: 1 = up, 3 = down, 2 = jump.
  function automatic logic [1:0] step_delta(input logic [1:0] new_idx, input logic [1:0] old_idx);
    return new_idx - old_idx;
  endfunction

endpackage

// File: rtl/led_wrap_monitor_if.sv
// LED bus, controls and decoded readback of the LED wrap monitor.
interface led_wrap_monitor_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       led;
  logic             pause;
  logic [CNT_W-1:0] maximum;
  logic             clr;

  logic [1:0]       pos;
  logic             pos_valid;
  logic             dir;
  logic             dir_valid;
  logic             step_pulse;
  logic [CNT_W-1:0] dwell;
  logic [15:0]      step_count;
  logic             err_pattern;
  logic             err_jump;
  logic             err_dwell;

  modport master (
    output led, pause, maximum, clr,
    input  pos, pos_valid, dir, dir_valid, step_pulse, dwell, step_count,
           err_pattern, err_jump, err_dwell
  );

  modport slave (
    input  led, pause, maximum, clr,
    output pos, pos_valid, dir, dir_valid, step_pulse, dwell, step_count,
           err_pattern, err_jump, err_dwell
  );
endinterface

// File: rtl/led_onehot_decode.sv
// Combinational decode of the 4-bit LED bus into {legal one-hot, off, index}.
module led_onehot_decode
  import led_wrap_pkg::*;
(
  input  logic [3:0] led,
  output logic       legal,
  output logic       off,
  output logic [1:0] idx
);

  always_comb begin
    legal = 1'b1;
    off   = 1'b0;
    idx   = 2'd0;
    case (led)
      LED_OFF: begin
        legal = 1'b0;
        off   = 1'b1;
      end
      LED_P0:  idx = 2'd0;
      LED_P1:  idx = 2'd1;
      LED_P2:  idx = 2'd2;
      LED_P3:  idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_wrap_monitor.sv
// Passive monitor of the wrap-around LED pattern: recovers position, direction
// and dwell per step, and raises sticky pattern/jump/dwell error flags.
module led_wrap_monitor
  import led_wrap_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  led_wrap_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [3:0]       led_q;
  logic [CNT_W-1:0] cnt;

  logic             dec_legal, dec_off;
  logic [1:0]       dec_idx;
  logic             chg;
  logic [1:0]       delta;

  logic             do_load, do_step, do_jump;
  logic             ev_pattern, ev_dwell;

  logic [1:0]       pos_r;
  logic             pos_valid_r, dir_r, dir_valid_r, step_pulse_r;
  logic [CNT_W-1:0] dwell_r;
  logic [15:0]      step_count_r;
  logic             err_pattern_r, err_jump_r, err_dwell_r;

  led_onehot_decode u_dec (
    .led   (bus.led),
    .legal (dec_legal),
    .off   (dec_off),
    .idx   (dec_idx)
  );

  assign chg   = (bus.led != led_q);
  assign delta = step_delta(dec_idx, pos_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_step    = 1'b0;
    do_jump    = 1'b0;
    ev_pattern = 1'b0;
    ev_dwell   = 1'b0;
    if (chg) begin
      if (!dec_legal && !dec_off) begin
        ev_pattern = 1'b1;
        state_nxt  = IDLE;
      end else if (dec_off) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            do_load   = 1'b1;
            state_nxt = ACQ;
          end
          ACQ, LOCK: begin
            if (delta == 2'd2) begin
              do_jump   = 1'b1;
              state_nxt = ACQ;
            end else if (delta != 2'd0) begin
              do_step   = 1'b1;
              state_nxt = LOCK;
              // First step after acquisition saw only part of its segment.
              ev_dwell  = (state == LOCK) && (bus.maximum != '0) && (cnt != bus.maximum);
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q         <= LED_OFF;
      cnt           <= '0;
      pos_r         <= 2'd0;
      pos_valid_r   <= 1'b0;
      dir_r         <= DIR_DN;
      dir_valid_r   <= 1'b0;
      step_pulse_r  <= 1'b0;
      dwell_r       <= '0;
      step_count_r  <= 16'd0;
      err_pattern_r <= 1'b0;
      err_jump_r    <= 1'b0;
      err_dwell_r   <= 1'b0;
    end else begin
      led_q <= bus.led;
      if (chg)
        cnt <= CNT_W'(1);
      else if (!bus.pause && cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);

      if (do_load || do_step || do_jump)
        pos_r <= dec_idx;
      if (do_step) begin
        dir_r        <= (delta == 2'd1) ? DIR_UP : DIR_DN;
        dwell_r      <= cnt;
        step_count_r <= step_count_r + 16'd1;
      end
      step_pulse_r <= do_step;
      pos_valid_r  <= (state_nxt != IDLE);
      dir_valid_r  <= (state_nxt == LOCK);

      // A new error event wins over a same-cycle clear.
      err_pattern_r <= (err_pattern_r && !bus.clr) || ev_pattern;
      err_jump_r    <= (err_jump_r    && !bus.clr) || do_jump;
      err_dwell_r   <= (err_dwell_r   && !bus.clr) || ev_dwell;
    end
  end

  assign bus.pos         = pos_r;
  assign bus.pos_valid   = pos_valid_r;
  assign bus.dir         = dir_r;
  assign bus.dir_valid   = dir_valid_r;
  assign bus.step_pulse  = step_pulse_r;
  assign bus.dwell       = dwell_r;
  assign bus.step_count  = step_count_r;
  assign bus.err_pattern = err_pattern_r;
  assign bus.err_jump    = err_jump_r;
  assign bus.err_dwell   = err_dwell_r;

endmodule

// File: tb/tb_led_wrap_monitor.sv
// Directed bench for led_wrap_monitor with a per-cycle reference model and literal spot checks.
module tb_led_wrap_monitor;

  logic clk = 1'b0;
  logic rst;

  led_wrap_monitor_if #(.CNT_W(8)) bus ();

  led_wrap_monitor #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Reference model: tracks what the decoded outputs must be from the LED history.
  logic [1:0]  e_pos       = 2'd0;
  logic        e_pos_valid = 1'b0;
  logic        e_dir       = 1'b0;
  logic        e_dir_valid = 1'b0;
  logic        e_pulse     = 1'b0;
  logic [7:0]  e_dwell     = 8'd0;
  logic [15:0] e_count     = 16'd0;
  logic        e_errp = 1'b0, e_errj = 1'b0, e_errd = 1'b0;
  logic [3:0]  m_prev = 4'd0;
  int          seg_len = 0;

  function automatic int onehot_index(input logic [3:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int idx, d, held;
    logic evp, evj, evd;
    if (!rst) begin
      e_pos = 0; e_pos_valid = 0; e_dir = 0; e_dir_valid = 0; e_pulse = 0;
      e_dwell = 0; e_count = 0; e_errp = 0; e_errj = 0; e_errd = 0;
      m_prev = 0; seg_len = 0;
    end else begin
      evp = 0; evj = 0; evd = 0;
      e_pulse = 0;
      held = (seg_len > 255) ? 255 : seg_len;
      if (bus.led != m_prev) begin
        idx = onehot_index(bus.led);
        if ($countones(bus.led) > 1) begin
          evp = 1; e_pos_valid = 0; e_dir_valid = 0;
        end else if (bus.led == 4'd0) begin
          e_pos_valid = 0; e_dir_valid = 0;
        end else if (!e_pos_valid) begin
          e_pos = idx[1:0]; e_pos_valid = 1;
        end else begin
          d = (idx - int'(e_pos) + 4) % 4;
          if (d == 2) begin
            evj = 1; e_pos = idx[1:0]; e_dir_valid = 0;
          end else begin
            e_pulse = 1;
            e_dir   = (d == 1);
            e_dwell = held[7:0];
            if (e_dir_valid && bus.maximum != 0 && held != int'(bus.maximum)) evd = 1;
            e_dir_valid = 1;
            e_pos   = idx[1:0];
            e_count = e_count + 16'd1;
          end
        end
        seg_len = 1;
      end else if (!bus.pause) begin
        seg_len++;
      end
      e_errp = (e_errp && !bus.clr) || evp;
      e_errj = (e_errj && !bus.clr) || evj;
      e_errd = (e_errd && !bus.clr) || evd;
      m_prev = bus.led;
    end
  end

  always @(negedge clk) begin
    chk("pos",         32'(bus.pos),         32'(e_pos));
    chk("pos_valid",   32'(bus.pos_valid),   32'(e_pos_valid));
    chk("dir",         32'(bus.dir),         32'(e_dir));
    chk("dir_valid",   32'(bus.dir_valid),   32'(e_dir_valid));
    chk("step_pulse",  32'(bus.step_pulse),  32'(e_pulse));
    chk("dwell",       32'(bus.dwell),       32'(e_dwell));
    chk("step_count",  32'(bus.step_count),  32'(e_count));
    chk("err_pattern", 32'(bus.err_pattern), 32'(e_errp));
    chk("err_jump",    32'(bus.err_jump),    32'(e_errj));
    chk("err_dwell",   32'(bus.err_dwell),   32'(e_errd));
  end

  task automatic drive(input logic [3:0] l, input logic p, input int n);
    bus.led   = l;
    bus.pause = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.led = 4'b0000; bus.pause = 1'b0; bus.maximum = 8'd0; bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_reset_pos_valid", 32'(bus.pos_valid), 0);
    chk("lit_reset_count",     32'(bus.step_count), 0);
    rst = 1'b1;

    // Upward sweep with full 20-cycle segments.
    bus.maximum = 8'd20;
    drive(4'b0001, 0, 20);
    drive(4'b0010, 0, 1);
    chk("lit_acq_lock_dir_valid", 32'(bus.dir_valid), 1);
    drive(4'b0010, 0, 19);
    drive(4'b0100, 0, 20);
    drive(4'b1000, 0, 20);
    drive(4'b0001, 0, 1);
    chk("lit_up_count", 32'(bus.step_count), 4);
    chk("lit_up_dwell", 32'(bus.dwell), 20);
    chk("lit_up_dir",   32'(bus.dir), 1);
    chk("lit_up_errs",  32'({bus.err_pattern, bus.err_jump, bus.err_dwell}), 0);
    drive(4'b0001, 0, 19);

    // Downward sweep, 10-cycle segments against maximum 20.
    drive(4'b0000, 0, 5);
    drive(4'b1000, 0, 10);
    drive(4'b0100, 0, 10);
    drive(4'b0010, 0, 1);
    chk("lit_dn_err_dwell", 32'(bus.err_dwell), 1);
    chk("lit_dn_dir",       32'(bus.dir), 0);
    drive(4'b0010, 0, 9);
    drive(4'b0001, 0, 10);
    drive(4'b1000, 0, 10);
    bus.clr = 1'b1;
    bus.maximum = 8'd15;
    drive(4'b1000, 0, 1);
    chk("lit_clr_err_dwell", 32'(bus.err_dwell), 0);
    bus.clr = 1'b0;
    drive(4'b1000, 0, 4);

    // Pause freezes the dwell counter.
    drive(4'b0100, 0, 15);
    drive(4'b0010, 0, 5);
    drive(4'b0010, 1, 5);
    drive(4'b0010, 0, 10);
    drive(4'b0001, 0, 1);
    chk("lit_pause_dwell",     32'(bus.dwell), 15);
    chk("lit_pause_err_dwell", 32'(bus.err_dwell), 0);
    drive(4'b0001, 0, 3);

    // Illegal pattern, then a two-position jump.
    drive(4'b0011, 0, 1);
    chk("lit_pat_err",       32'(bus.err_pattern), 1);
    chk("lit_pat_pos_valid", 32'(bus.pos_valid), 0);
    drive(4'b0001, 0, 3);
    drive(4'b0100, 0, 1);
    chk("lit_jump_err",   32'(bus.err_jump), 1);
    chk("lit_jump_pulse", 32'(bus.step_pulse), 0);
    chk("lit_jump_pos",   32'(bus.pos), 2);
    drive(4'b0100, 0, 3);
    drive(4'b1000, 0, 5);

    // Asynchronous reset mid-operation.
    rst = 1'b0;
    #1;
    chk("lit_rst_count",     32'(bus.step_count), 0);
    chk("lit_rst_pos_valid", 32'(bus.pos_valid), 0);
    chk("lit_rst_errs",      32'({bus.err_pattern, bus.err_jump, bus.err_dwell}), 0);
    chk("lit_rst_pos",       32'(bus.pos), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(4'b1000, 0, 1);
    chk("lit_rel_pos_valid", 32'(bus.pos_valid), 1);
    chk("lit_rel_dir_valid", 32'(bus.dir_valid), 0);
    chk("lit_rel_pulse",     32'(bus.step_pulse), 0);
    chk("lit_rel_pos",       32'(bus.pos), 3);

    // Dwell counter saturation with the check disabled.
    bus.maximum = 8'd0;
    drive(4'b1000, 0, 299);
    drive(4'b0001, 0, 1);
    chk("lit_sat_dwell",     32'(bus.dwell), 255);
    chk("lit_sat_pulse",     32'(bus.step_pulse), 1);
    chk("lit_sat_err_dwell", 32'(bus.err_dwell), 0);
    chk("lit_sat_count",     32'(bus.step_count), 1);
    drive(4'b0001, 0, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
